// File: rtl/frame_extraction_pkg.sv
// Shared definitions for the frame extraction block: FSM encodings and
// the width of the per-beat frame index.
package frame_extraction_pkg;

    localparam int unsigned IDX_W = 16;
    typedef logic [IDX_W-1:0] idx_t;

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_DROP = 1'b1;

endpackage

// File: rtl/frame_extraction_if.sv
// Stream bundle for frame_extraction: framed slave input, re-framed master
// output with its frame-position sideband (sof_m, idx_m).
interface frame_extraction_if #(
    parameter int unsigned DW = 16
) ();
    import frame_extraction_pkg::*;

    logic [DW-1:0] tdata_s;
    logic          tvalid_s;
    logic          tlast_s;
    logic          tready_s;

    logic [DW-1:0] tdata_m;
    logic          tvalid_m;
    logic          tlast_m;
    logic          tready_m;
    logic          sof_m;
    idx_t          idx_m;

    // slave: the frame_extraction side; master: whoever feeds and drains it
    modport slave (
        input  tdata_s, tvalid_s, tlast_s, tready_m,
        output tready_s, tdata_m, tvalid_m, tlast_m, sof_m, idx_m
    );

    modport master (
        output tdata_s, tvalid_s, tlast_s, tready_m,
        input  tready_s, tdata_m, tvalid_m, tlast_m, sof_m, idx_m
    );

endinterface

// File: rtl/frame_extraction_skid.sv
// Two-entry output buffer with a registered in_ready: full throughput while
// out_ready stays high, and in_ready never depends combinationally on out_ready.
module axis_skid_buffer #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    input  logic         out_ready
);

    logic [1:0]   count;
    logic [1:0]   count_nxt;
    logic [W-1:0] slot0;
    logic [W-1:0] slot1;
    logic         push;
    logic         pop;

    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign out_valid = (count != 2'd0);
    assign out_data  = slot0;

    always_comb begin
        count_nxt = count;
        if (push && !pop)
            count_nxt = count + 2'd1;
        else if (pop && !push)
            count_nxt = count - 2'd1;
    end

    // slot0 is always the head; slot1 only fills while the head is stalled
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count    <= '0;
            slot0    <= '0;
            slot1    <= '0;
            in_ready <= 1'b1;
        end else begin
            count    <= count_nxt;
            in_ready <= (count_nxt != 2'd2);
            if (push && (count == 2'd0 || (count == 2'd1 && pop)))
                slot0 <= in_data;
            else if (pop && count == 2'd2)
                slot0 <= slot1;
            if (push && !pop && count == 2'd1)
                slot1 <= in_data;
        end
    end

endmodule

// File: rtl/frame_extraction.sv
// Re-frames a stream to fixed FRAME_LEN frames: tags each beat with its index,
// terminates short frames, truncates long ones and drops their excess beats.
module frame_extraction
    import frame_extraction_pkg::*;
#(
    parameter int unsigned DW        = 16,
    parameter int unsigned FRAME_LEN = 1024,
    parameter int unsigned CW        = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          ce,
    input  logic          clear,
    frame_extraction_if.slave bus,
    output logic          frame_ok,
    output logic          err_short,
    output logic          err_long,
    output logic [CW-1:0] frame_cnt,
    output logic [CW-1:0] short_cnt,
    output logic [CW-1:0] long_cnt
);

    localparam int unsigned PW       = DW + 2 + IDX_W;
    localparam idx_t        LAST_POS = idx_t'(FRAME_LEN - 1);

    logic [0:0]    state;
    idx_t          pos;
    logic          buf_ready;
    logic          accept;
    logic          at_last;
    logic          skid_in_valid;
    logic [PW-1:0] in_payload;
    logic [PW-1:0] out_payload;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == '1) ? v : v + CW'(1);
    endfunction

    assign bus.tready_s  = buf_ready & ce;
    assign accept        = bus.tvalid_s & bus.tready_s;
    assign at_last       = (pos == LAST_POS);
    assign skid_in_valid = bus.tvalid_s & ce & (state == ST_RUN);
    assign in_payload    = {bus.tdata_s, bus.tlast_s | at_last, pos == '0, pos};

    assign {bus.tdata_m, bus.tlast_m, bus.sof_m, bus.idx_m} = out_payload;

    axis_skid_buffer #(.W(PW)) u_skid (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (skid_in_valid),
        .in_data   (in_payload),
        .in_ready  (buf_ready),
        .out_valid (bus.tvalid_m),
        .out_data  (out_payload),
        .out_ready (bus.tready_m)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_RUN;
            pos       <= '0;
            frame_ok  <= 1'b0;
            err_short <= 1'b0;
            err_long  <= 1'b0;
            frame_cnt <= '0;
            short_cnt <= '0;
            long_cnt  <= '0;
        end else begin
            frame_ok  <= 1'b0;
            err_short <= 1'b0;
            err_long  <= 1'b0;
            if (accept) begin
                if (state == ST_RUN) begin
                    if (bus.tlast_s) begin
                        pos <= '0;
                        if (at_last) begin
                            frame_ok  <= 1'b1;
                            frame_cnt <= sat_inc(frame_cnt);
                        end else begin
                            err_short <= 1'b1;
                            short_cnt <= sat_inc(short_cnt);
                        end
                    end else if (at_last) begin
                        pos      <= pos + idx_t'(1);
                        state    <= ST_DROP;
                        err_long <= 1'b1;
                        long_cnt <= sat_inc(long_cnt);
                    end else begin
                        pos <= pos + idx_t'(1);
                    end
                end else if (bus.tlast_s) begin
                    pos   <= '0;
                    state <= ST_RUN;
                end else begin
                    pos <= pos + idx_t'(1);
                end
            end
            // Placed last so a coinciding event cannot survive the clear
            if (clear) begin
                pos       <= '0;
                state     <= ST_RUN;
                frame_cnt <= '0;
                short_cnt <= '0;
                long_cnt  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_frame_extraction.sv
// Directed bench for frame_extraction with FRAME_LEN=8; a second instance
// with 2-bit counters shares the stimulus to exercise saturation.
`timescale 1ns/1ps
module tb_frame_extraction;
    import frame_extraction_pkg::*;

    localparam int unsigned DW     = 16;
    localparam int unsigned FL     = 8;
    localparam int unsigned CW     = 16;
    localparam int unsigned CW_SAT = 2;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          last;
        logic          sof;
        idx_t          idx;
    } beat_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic ce = 1'b0;
    logic clear = 1'b0;

    logic              frame_ok, err_short, err_long;
    logic [CW-1:0]     frame_cnt, short_cnt, long_cnt;
    logic              frame_ok1, err_short1, err_long1;
    logic [CW_SAT-1:0] frame_cnt1, short_cnt1, long_cnt1;

    frame_extraction_if #(.DW(DW)) bus ();
    frame_extraction_if #(.DW(DW)) bus1 ();

    assign bus1.tdata_s  = bus.tdata_s;
    assign bus1.tvalid_s = bus.tvalid_s;
    assign bus1.tlast_s  = bus.tlast_s;
    assign bus1.tready_m = bus.tready_m;

    frame_extraction #(.DW(DW), .FRAME_LEN(FL), .CW(CW)) dut (
        .clk(clk), .reset_n(reset_n), .ce(ce), .clear(clear), .bus(bus),
        .frame_ok(frame_ok), .err_short(err_short), .err_long(err_long),
        .frame_cnt(frame_cnt), .short_cnt(short_cnt), .long_cnt(long_cnt)
    );

    frame_extraction #(.DW(DW), .FRAME_LEN(FL), .CW(CW_SAT)) dut_sat (
        .clk(clk), .reset_n(reset_n), .ce(ce), .clear(clear), .bus(bus1),
        .frame_ok(frame_ok1), .err_short(err_short1), .err_long(err_long1),
        .frame_cnt(frame_cnt1), .short_cnt(short_cnt1), .long_cnt(long_cnt1)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    int unsigned acc_cnt = 0;
    int unsigned ok_n = 0, short_n = 0, long_n = 0;
    int unsigned out_rd = 0;
    logic        tready_hold = 1'b1;
    logic        bp_en = 1'b0;
    logic        bp_mon = 1'b0;
    int          occ = 0;
    int unsigned bp_viol = 0, bp_full = 0;
    beat_t       out_q[$];
    beat_t       exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // tready_m changes only just after a rising edge
    initial begin
        bus.tready_m = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.tready_m = bp_en ? 1'($urandom_range(0, 1)) : tready_hold;
        end
    end

    always @(negedge clk) begin
        if (bus.tvalid_m === 1'b1 && bus.tready_m === 1'b1)
            out_q.push_back({bus.tdata_m, bus.tlast_m, bus.sof_m, bus.idx_m});
        if (bus.tvalid_s === 1'b1 && bus.tready_s === 1'b1)
            acc_cnt++;
        ok_n    += 32'(frame_ok === 1'b1);
        short_n += 32'(err_short === 1'b1);
        long_n  += 32'(err_long === 1'b1);
        if (!bp_mon) begin
            occ = 0;
        end else begin
            if (bus.tready_s !== (occ != 2)) bp_viol++;
            if (occ == 2) bp_full++;
            occ += int'(bus.tvalid_s && bus.tready_s) - int'(bus.tvalid_m && bus.tready_m);
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [DW-1:0] d, input logic last);
        logic acc;
        int   n;
        acc = 1'b0;
        n   = 0;
        bus.tdata_s  = d;
        bus.tlast_s  = last;
        bus.tvalid_s = 1'b1;
        do begin
            @(negedge clk);
            acc = bus.tready_s;
            tick();
            n++;
        end while (acc !== 1'b1 && n < 100);
        if (acc !== 1'b1) chk("send_timeout", 64'(acc), 64'(1));
    endtask

    task automatic idle();
        bus.tvalid_s = 1'b0;
        bus.tlast_s  = 1'b0;
    endtask

    task automatic expb(input logic [DW-1:0] d, input logic last, input logic sof, input int idx);
        exp_q.push_back({d, last, sof, idx_t'(idx)});
    endtask

    task automatic drain_and_compare(input string tag);
        int unsigned n;
        idle();
        repeat (6) tick();
        n = exp_q.size();
        chk($sformatf("%s_count", tag), 64'(out_q.size() - out_rd), 64'(n));
        for (int unsigned i = 0; i < n; i++)
            if (out_rd + i < out_q.size())
                chk($sformatf("%s_beat%0d", tag, i), 64'(out_q[out_rd + i]), 64'(exp_q[i]));
        out_rd = out_q.size();
        exp_q.delete();
    endtask

    initial begin
        int unsigned c0, a0, ok0, sh0, lg0;

        bus.tdata_s  = '0;
        bus.tvalid_s = 1'b0;
        bus.tlast_s  = 1'b0;
        ce           = 1'b1;
        repeat (2) tick();
        chk("rst_tvalid_m", 64'(bus.tvalid_m), 64'(0));
        chk("rst_tdata_m",  64'(bus.tdata_m),  64'(0));
        chk("rst_idx_m",    64'(bus.idx_m),    64'(0));
        chk("rst_sof_tlast", 64'({bus.sof_m, bus.tlast_m}), 64'(0));
        chk("rst_pulses",   64'({frame_ok, err_short, err_long}), 64'(0));
        chk("rst_counters", 64'({frame_cnt, short_cnt, long_cnt}), 64'(0));
        chk("rst_tready_s", 64'(bus.tready_s), 64'(1));
        reset_n = 1'b1;
        tick();

        // three good back-to-back frames
        ok0 = ok_n;
        c0  = cyc;
        for (int i = 0; i < 24; i++) begin
            send(16'(32'hA000 + i), (i % 8) == 7);
            expb(16'(32'hA000 + i), (i % 8) == 7, (i % 8) == 0, i % 8);
            if (i == 0) begin
                chk("latency_tvalid", 64'(bus.tvalid_m), 64'(1));
                chk("latency_tdata",  64'(bus.tdata_m),  64'(16'hA000));
            end
        end
        chk("throughput_cycles", 64'(cyc - c0), 64'(24));
        drain_and_compare("good");
        chk("good_frame_cnt", 64'(frame_cnt), 64'(3));
        chk("good_err_cnts",  64'({short_cnt, long_cnt}), 64'(0));
        chk("good_ok_pulses", 64'(ok_n - ok0), 64'(3));

        // short frame: tlast on beat 4, then a clean frame
        sh0 = short_n;
        for (int i = 0; i < 5; i++) begin
            send(16'(32'hB000 + i), i == 4);
            expb(16'(32'hB000 + i), i == 4, i == 0, i);
        end
        chk("short_pulse_timing", 64'(err_short), 64'(1));
        for (int i = 0; i < 8; i++) begin
            send(16'(32'hB100 + i), i == 7);
            expb(16'(32'hB100 + i), i == 7, i == 0, i);
        end
        drain_and_compare("short");
        chk("short_cnt",    64'(short_cnt), 64'(1));
        chk("short_pulses", 64'(short_n - sh0), 64'(1));
        chk("short_frame_cnt", 64'(frame_cnt), 64'(4));

        // long frame: 11 beats, beats 8..10 dropped
        lg0 = long_n;
        for (int i = 0; i < 11; i++) begin
            send(16'(32'hC000 + i), i == 10);
            if (i < 8) expb(16'(32'hC000 + i), i == 7, i == 0, i);
            if (i == 7) chk("long_pulse_timing", 64'(err_long), 64'(1));
        end
        for (int i = 0; i < 8; i++) begin
            send(16'(32'hD000 + i), i == 7);
            expb(16'(32'hD000 + i), i == 7, i == 0, i);
        end
        drain_and_compare("long");
        chk("long_cnt",    64'(long_cnt), 64'(1));
        chk("long_pulses", 64'(long_n - lg0), 64'(1));
        chk("long_frame_cnt", 64'(frame_cnt), 64'(5));

        // 1000 beats under random backpressure
        bp_mon = 1'b1;
        bp_en  = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            send(16'(i * 37 + 5), (i % 8) == 7);
            expb(16'(i * 37 + 5), (i % 8) == 7, (i % 8) == 0, i % 8);
        end
        idle();
        bp_en       = 1'b0;
        tready_hold = 1'b1;
        repeat (6) tick();
        bp_mon = 1'b0;
        drain_and_compare("bp");
        chk("bp_ready_rule", 64'(bp_viol), 64'(0));
        chk("bp_full_seen",  64'(bp_full != 0), 64'(1));
        chk("bp_frame_cnt",  64'(frame_cnt), 64'(130));

        // ce low for 5 cycles with a stalled output, then clear on the frame_ok beat
        for (int i = 0; i < 4; i++) begin
            send(16'(32'hE000 + i), 1'b0);
            expb(16'(32'hE000 + i), 1'b0, i == 0, i);
        end
        tready_hold = 1'b0;
        send(16'hE004, 1'b0);
        expb(16'hE004, 1'b0, 1'b0, 4);
        ce = 1'b0;
        bus.tdata_s = 16'hE005;
        a0 = acc_cnt;
        repeat (5) begin
            tick();
            chk("ce_tready_s", 64'(bus.tready_s), 64'(0));
            chk("ce_hold_out", 64'({bus.tvalid_m, bus.tdata_m, bus.tlast_m, bus.sof_m, bus.idx_m}),
                64'({1'b1, 16'hE004, 1'b0, 1'b0, 16'd4}));
        end
        chk("ce_no_accept", 64'(acc_cnt - a0), 64'(0));
        ce = 1'b1;
        tready_hold = 1'b1;
        for (int i = 5; i < 7; i++) begin
            send(16'(32'hE000 + i), 1'b0);
            expb(16'(32'hE000 + i), 1'b0, 1'b0, i);
        end
        clear = 1'b1;
        send(16'hE007, 1'b1);
        clear = 1'b0;
        expb(16'hE007, 1'b1, 1'b0, 7);
        chk("clear_wins_frame_cnt", 64'(frame_cnt), 64'(0));
        chk("clear_err_cnts", 64'({short_cnt, long_cnt}), 64'(0));

        // clear mid-frame restarts the index
        for (int i = 0; i < 3; i++) begin
            send(16'(32'hF000 + i), 1'b0);
            expb(16'(32'hF000 + i), 1'b0, i == 0, i);
        end
        idle();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        for (int i = 0; i < 8; i++) begin
            send(16'(32'hF100 + i), i == 7);
            expb(16'(32'hF100 + i), i == 7, i == 0, i);
        end
        drain_and_compare("ce_clear");
        chk("clear_pos_frame_cnt", 64'(frame_cnt), 64'(1));

        // asynchronous reset with a beat held in the buffer
        send(16'h9000, 1'b0);
        expb(16'h9000, 1'b0, 1'b1, 0);
        send(16'h9001, 1'b0);
        expb(16'h9001, 1'b0, 1'b0, 1);
        tready_hold = 1'b0;
        send(16'h9002, 1'b0);
        bus.tdata_s = 16'h9003;
        chk("prerst_tvalid_m", 64'(bus.tvalid_m), 64'(1));
        #1;
        reset_n = 1'b0;
        #1;
        chk("arst_tvalid_m", 64'(bus.tvalid_m), 64'(0));
        chk("arst_tdata_idx", 64'({bus.tdata_m, bus.idx_m}), 64'(0));
        chk("arst_sof_tlast", 64'({bus.sof_m, bus.tlast_m}), 64'(0));
        chk("arst_frame_cnt", 64'(frame_cnt), 64'(0));
        chk("arst_tready_s", 64'(bus.tready_s), 64'(1));
        idle();
        tick();
        tick();
        reset_n = 1'b1;
        tready_hold = 1'b1;
        drain_and_compare("pre_reset");
        for (int i = 0; i < 8; i++) begin
            send(16'(32'h7000 + i), i == 7);
            expb(16'(32'h7000 + i), i == 7, i == 0, i);
        end
        drain_and_compare("post_reset");
        chk("post_reset_frame_cnt", 64'(frame_cnt), 64'(1));

        // four more good frames: the 2-bit counter saturates at 3
        for (int i = 0; i < 32; i++) begin
            send(16'(32'h6000 + i), (i % 8) == 7);
            expb(16'(32'h6000 + i), (i % 8) == 7, (i % 8) == 0, i % 8);
        end
        drain_and_compare("sat");
        chk("sat_frame_cnt_wide", 64'(frame_cnt), 64'(5));
        chk("sat_frame_cnt_2bit", 64'(frame_cnt1), 64'(3));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
